// File: rtl/aes_pkg.sv
// Shared AES definitions: block/column widths, GF(2^8) reduction constant,
// the MixColumns controller state type and constant-coefficient multipliers.
package aes_pkg;

  localparam int          AES_BLOCK_W = 128;
  localparam int          AES_COL_W   = 32;
  localparam logic [7:0]  AES_POLY    = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by one of the fixed MixColumns / InvMixColumns coefficients.
  // Higher coefficients are assembled from chained xtime terms.
  function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [7:0] coeff);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] res;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (coeff)
      8'h01:   res = b;
      8'h02:   res = x2;
      8'h03:   res = x2 ^ b;
      8'h09:   res = x8 ^ b;
      8'h0b:   res = x8 ^ x2 ^ b;
      8'h0d:   res = x8 ^ x4 ^ b;
      8'h0e:   res = x8 ^ x4 ^ x2;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column. Byte r of the column
// occupies bits [8r : 8r+7]; row 0 is the leftmost byte.
module mix_single_column
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [0:31] col_in,
  output logic [0:31] col_out
);

  // Coefficient row of the circulant matrix; later rows are rotations.
  localparam logic [7:0] C0 = INVERSE ? 8'h0e : 8'h02;
  localparam logic [7:0] C1 = INVERSE ? 8'h0b : 8'h03;
  localparam logic [7:0] C2 = INVERSE ? 8'h0d : 8'h01;
  localparam logic [7:0] C3 = INVERSE ? 8'h09 : 8'h01;

  logic [7:0] a0, a1, a2, a3;

  // Split the column into rows and apply the rotated coefficient row per output byte.
  always_comb begin
    a0 = col_in[0:7];
    a1 = col_in[8:15];
    a2 = col_in[16:23];
    a3 = col_in[24:31];
    col_out[0:7]   = gmul_const(a0, C0) ^ gmul_const(a1, C1) ^ gmul_const(a2, C2) ^ gmul_const(a3, C3);
    col_out[8:15]  = gmul_const(a1, C0) ^ gmul_const(a2, C1) ^ gmul_const(a3, C2) ^ gmul_const(a0, C3);
    col_out[16:23] = gmul_const(a2, C0) ^ gmul_const(a3, C1) ^ gmul_const(a0, C2) ^ gmul_const(a1, C3);
    col_out[24:31] = gmul_const(a3, C0) ^ gmul_const(a0, C1) ^ gmul_const(a1, C2) ^ gmul_const(a2, C3);
  end

endmodule

// File: rtl/mix_columns.sv
// Column-serial AES MixColumns stage. A rising edge on enableMixColumns
// latches the block; one column is mixed per clock and the finished block is
// published on stateOut together with mixColumnsDone. Final-round starts
// (lastRound=1) publish the latched block unchanged one edge later.
module mix_columns
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enableMixColumns,
  input  logic         lastRound,
  input  logic [0:127] state,
  output logic [0:127] stateOut,
  output logic         mixColumnsDone
);

  mc_state_e    fsm, fsm_nxt;
  logic         en_q;
  logic         last_q;
  logic [1:0]   col;
  logic [0:127] work;
  logic [0:127] work_nxt;
  logic [0:31]  mix_in;
  logic [0:31]  mix_out;

  logic start;
  logic load;
  logic step;
  logic finish;
  logic publish_byp;

  mix_single_column #(.INVERSE(INVERSE)) u_col (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_nxt;
  end

  // Next-state logic: starts are honoured only outside CALC.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE, DONE: if (load)   fsm_nxt = lastRound ? DONE : CALC;
      CALC:       if (finish) fsm_nxt = DONE;
      default:                fsm_nxt = IDLE;
    endcase
  end

  // Control decode: edge detect and per-cycle actions.
  always_comb begin
    start       = enableMixColumns & ~en_q;
    load        = start && (fsm != CALC);
    step        = (fsm == CALC);
    finish      = step && (col == 2'd3);
    publish_byp = (fsm == DONE) && last_q && !mixColumnsDone;
  end

  // Select the current column and splice its mixed value back into the block.
  always_comb begin
    mix_in                = work[32*col +: 32];
    work_nxt              = work;
    work_nxt[32*col +: 32] = mix_out;
  end

  // Enable history for rising-edge detection; updates even while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_q <= 1'b0;
    else      en_q <= enableMixColumns;
  end

  // Working register, column counter and published result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work           <= '0;
      last_q         <= 1'b0;
      col            <= 2'd0;
      stateOut       <= '0;
      mixColumnsDone <= 1'b0;
    end else if (load) begin
      work           <= state;
      last_q         <= lastRound;
      col            <= 2'd0;
      mixColumnsDone <= 1'b0;
    end else if (step) begin
      work <= work_nxt;
      col  <= col + 2'd1;
      if (finish) begin
        stateOut       <= work_nxt;
        mixColumnsDone <= 1'b1;
      end
    end else if (publish_byp) begin
      stateOut       <= work;
      mixColumnsDone <= 1'b1;
    end
  end

endmodule

// File: doc/mix_columns.md
Name: mix_columns

Overview:
- AES MixColumns stage; sits directly downstream of the ShiftRows stage and consumes its 128-bit stateOut and its done flag.
- Column-serial datapath: one 32-bit column per clock, 4 compute cycles per block.
- Final-round bypass (`lastRound`) passes the state through unchanged, since AES round 10 has no MixColumns.
- INVERSE parameter selects InvMixColumns for the decrypt path.

Parameters:
- INVERSE, 0, 0 = MixColumns (coefficients 02 03 01 01); 1 = InvMixColumns (coefficients 0e 0b 0d 09).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enableMixColumns  input  1  start request, level signal driven by upstream done; only a rising edge starts work.
- lastRound  input  1  sampled with the start edge; 1 = bypass.
- state  input  128  [0:127]; column c = bits [32c:32c+31]; row r of column c = bits [32c+8r : 32c+8r+7].
- stateOut  output reg  128  [0:127]; result, same byte layout as `state`.
- mixColumnsDone  output reg  1  high while stateOut holds a valid result for the last start.

Behaviour:
- Reset: while rst=0, all of the following are cleared asynchronously and immediately, including mid-operation; no partial result is ever published:
  - stateOut=0, mixColumnsDone=0;
  - FSM=IDLE, column counter=0, working register=0;
  - enable history register=0.
- Start edge detection: a start edge occurs on a clock edge where enableMixColumns=1 and the registered previous value=0.
  - A level held high never retriggers.
- FSM states: IDLE, CALC, DONE.
- Start edge E, accepted only in IDLE or DONE:
  - latch `state` into the working register and `lastRound` into a flag;
  - clear mixColumnsDone;
  - next state is CALC, or DONE if lastRound=1.
- CALC: on each edge, column `col` (0..3) of the working register is replaced by its mixed value; col increments.
  - On the edge where col=3: stateOut <= fully mixed block, mixColumnsDone <= 1, col <= 0, FSM -> DONE.
  - Latency: done is high after edge E+4.
- Bypass (lastRound=1): at edge E+1, stateOut <= latched state unchanged and mixColumnsDone <= 1.
- DONE: stateOut and done are held until the next start edge or reset.
- A start edge during CALC is ignored; the history register still updates.
  - Upstream must drop and re-raise enable to start again.
- stateOut changes only on completion; it holds its previous value throughout CALC.
- Arithmetic is in GF(2^8), reduction polynomial 0x11b.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - Forward: b0 = 2a0^3a1^a2^a3, then rotate the coefficients for b1..b3.
  - Inverse: b0 = 0e·a0^0b·a1^0d·a2^09·a3, then rotate likewise.
  - 0e, 0b, 0d and 09 are built from chained xtime and XOR.
- No multi-cycle or combinational paths from input to output; stateOut is registered.

Decomposition:
- Package aes_pkg holds:
  - constants AES_BLOCK_W=128, AES_COL_W=32, AES_POLY=8'h1b;
  - the FSM state enum (IDLE, CALC, DONE);
  - function xtime and function gmul_const(byte, coeff) for 02/03/09/0b/0d/0e.
- Sub-module mix_single_column (combinational, 32 bit in / 32 bit out, INVERSE param) is instantiated once and muxed by col.

Test Plan:
- Reset: rst=0 mid-CALC (after 2 columns) -> stateOut=0 and done=0 immediately; after release, a fresh start gives the correct full result.
- FIPS-197 Appendix B round 1:
  - state = d4bf5d30 e0b452ae b84111f1 1e2798e5, pulse enable;
  - -> stateOut = 046681e5 e0cb199a 48f8d37a 2806264c;
  - done rises exactly after edge E+4.
- Column vectors, INVERSE=0:
  - db135345 -> 8e4da1bc; f20a225c -> 9fdc589d;
  - 01010101 -> 01010101; d4d4d4d5 -> d5d5d7d6 (packed as the four columns of one block).
- INVERSE=1, columns 8e4da1bc 9fdc589d 01010101 d5d5d7d6 -> db135345 f20a225c 01010101 d4d4d4d5.
- Bypass: lastRound=1 with an arbitrary state -> stateOut=state and done=1 after edge E+1.
- Handshake:
  - enable held high for 20 cycles -> exactly one computation;
  - enable toggled low then high during CALC -> ignored, result unchanged;
  - re-raise after DONE -> done drops on E, then rises again 4 edges later with the new result.
